hazard_unit_sb: RTL

- Next-generation hazard unit for the RV32I 5-stage pipeline.
- Existing functions: M/W forwarding, load-use stall and branch flush, now with x0 guarding.
- Adds a scoreboard for one multi-cycle execute unit (MUL/DIV) with parametrised latency.
- Adds a whole-pipe freeze for a variable-latency data memory (dmem_ready handshake).
- Sits beside the datapath; drives all stall/flush/forward selects.

---
 rtl/hazard_unit_sb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: RV32I 5-stage hazard unit with M/W forwarding, load-use stall, branch flush, mc scoreboard and dmem freeze
module hazard_unit_sb #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int FWD_WB = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite_M,
  input  logic              regWrite_W,
  input  logic              PCSrc_E,
  input  logic [1:0]        resultSrc_E,
  input  logic [1:0]        resultSrc_M,
  input  logic              dmem_ready,
  input  logic              mc_D,
  input  logic              mc_start_E,
  input  logic              regWrite_D,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rd_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushW,
  output logic              mc_busy,
  output logic              mc_wb_valid,
  output logic [REG_AW-1:0] mc_wb_rd
);
  localparam int NR = 1 << REG_AW;
  localparam int CW = $clog2(MC_LAT);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [NR-1:0]     r_busy;
  logic [REG_AW-1:0] r_mc_rd;

  logic [NR-1:0] w_busy;
  logic          w_mem_stall;
  logic          w_load_use;
  logic          w_sb_raw;
  logic          w_sb_waw;
  logic          w_mc_struct;
  logic          w_d_stall;
  logic          w_issue;
  logic          w_fwd_wb;

  assign w_fwd_wb = (FWD_WB != 0);

  // Forward selects: M beats W, x0 never forwarded
  always_comb begin
    forwardAE = (regWrite_M && rd_M == rs1_E && rd_M != '0) ? 2'b10 :
                (w_fwd_wb && regWrite_W && rd_W == rs1_E && rd_W != '0) ? 2'b01 : 2'b00;
    forwardBE = (regWrite_M && rd_M == rs2_E && rd_M != '0) ? 2'b10 :
                (w_fwd_wb && regWrite_W && rd_W == rs2_E && rd_W != '0) ? 2'b01 : 2'b00;
  end

  // Hazard terms; bit 0 of the scoreboard is masked so x0 never stalls
  always_comb begin
    w_busy      = r_busy & ~NR'(1);
    w_mem_stall = (resultSrc_M == 2'b01) && !dmem_ready;
    w_load_use  = (resultSrc_E == 2'b01) && rd_E != '0 && (rd_E == rs1_D || rd_E == rs2_D);
    w_sb_raw    = w_busy[rs1_D] || w_busy[rs2_D];
    w_sb_waw    = regWrite_D && w_busy[rd_D];
    w_mc_struct = mc_D && (r_state != S_IDLE);
    w_d_stall   = w_load_use | w_sb_raw | w_sb_waw | w_mc_struct;
    w_issue     = mc_start_E && !w_mem_stall;
  end

  // Stall/flush: a dmem wait freezes the whole pipe and defers any branch flush
  always_comb begin
    stallF = w_mem_stall | w_d_stall;
    stallD = w_mem_stall | w_d_stall;
    stallE = w_mem_stall;
    stallM = w_mem_stall;
    flushW = w_mem_stall;
    flushD = !w_mem_stall && PCSrc_E;
    flushE = !w_mem_stall && (w_d_stall || PCSrc_E);
  end

  // Multi-cycle unit tracker: issue -> BUSY countdown -> one-cycle DONE writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= '0;
      r_mc_rd <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_issue) begin
          r_state <= S_BUSY;
          r_cnt   <= CW'(MC_LAT - 2);
          r_mc_rd <= rd_E;
          if (rd_E != '0) r_busy[rd_E] <= 1'b1;
        end
        S_BUSY: if (r_cnt == '0) r_state <= S_DONE; else r_cnt <= r_cnt - 1'b1;
        S_DONE: begin
          r_busy[r_mc_rd] <= 1'b0;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mc_busy     = (r_state != S_IDLE);
  assign mc_wb_valid = (r_state == S_DONE);
  assign mc_wb_rd    = r_mc_rd;
endmodule
